// File: rtl/dmac_slave.sv
// dmac_slave: register-mapped slave side of a simple DMA controller.
// It holds the transfer setup registers, drives the start, clear and mode
// controls to the DMA master, and queues transfer descriptors
// {source, destination, size} in an 8-deep FIFO that the master pops.
//
// Ports:
//   clk, reset_n               clock and asynchronous active-low reset
//   s_sel, s_wr, s_addr, s_din register bus input; only s_addr[7:0] is decoded
//   s_dout                     registered read data (0 when not reading)
//   op_start, op_clear, op_mode  controls to the master
//   op_done                    completion flag from the master
//   rd_en                      descriptor pop request from the master
//   source_addr, dest_addr, data_size  the descriptor most recently popped
//   data_count                 FIFO occupancy, 0..8
//   interrupt                  combinational op_done & int_en
module dmac_slave (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s_sel,
  input  logic        s_wr,
  input  logic [15:0] s_addr,
  input  logic [31:0] s_din,
  output logic [31:0] s_dout,
  output logic        op_start,
  output logic        op_clear,
  output logic [1:0]  op_mode,
  input  logic        op_done,
  input  logic        rd_en,
  output logic [15:0] source_addr,
  output logic [15:0] dest_addr,
  output logic [15:0] data_size,
  output logic [3:0]  data_count,
  output logic        interrupt
);

  localparam int unsigned DEPTH = 8;
  localparam int unsigned PTR_W = 3;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned HW    = 16;

  localparam logic [7:0] A_START  = 8'h00;
  localparam logic [7:0] A_INT_EN = 8'h01;
  localparam logic [7:0] A_SRC    = 8'h02;
  localparam logic [7:0] A_DST    = 8'h03;
  localparam logic [7:0] A_SIZE   = 8'h04;
  localparam logic [7:0] A_PUSH   = 8'h05;
  localparam logic [7:0] A_MODE   = 8'h06;
  localparam logic [7:0] A_CLEAR  = 8'h07;
  localparam logic [7:0] A_STATUS = 8'h08;

  typedef struct packed {
    logic [HW-1:0] src;
    logic [HW-1:0] dst;
    logic [HW-1:0] size;
  } desc_t;

  logic [7:0]       addr;
  logic             wr_c, rd_c;
  logic             push_c, pop_c, push_ok_c, ovf_set_c;
  logic             full_c, empty_c;
  logic             int_en;
  logic [HW-1:0]    src_reg, dst_reg, size_reg;
  logic             overflow;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count_nxt_c;
  logic [31:0]      rdata_c;
  desc_t            mem [DEPTH];
  desc_t            head_c;

  // Upper address bits and upper write-data bits carry no meaning here
  logic unused_bits;
  assign unused_bits = ^{s_addr[15:8], s_din[31:16]};

  assign addr    = s_addr[7:0];
  assign wr_c    = s_sel & s_wr;
  assign rd_c    = s_sel & ~s_wr;
  assign full_c  = (data_count == CNT_W'(DEPTH));
  assign empty_c = (data_count == '0);
  assign head_c  = mem[rd_ptr];

  // A push into a full FIFO is accepted only when a pop frees a slot that cycle
  assign push_c    = wr_c && (addr == A_PUSH);
  assign pop_c     = rd_en && !empty_c;
  assign push_ok_c = push_c && (!full_c || pop_c);
  assign ovf_set_c = push_c && full_c && !pop_c;

  assign interrupt = op_done & int_en;

  // Occupancy update
  always_comb begin
    count_nxt_c = data_count;
    case ({push_ok_c, pop_c})
      2'b10:   count_nxt_c = data_count + CNT_W'(1);
      2'b01:   count_nxt_c = data_count - CNT_W'(1);
      default: count_nxt_c = data_count;
    endcase
  end

  // Read-data mux
  always_comb begin
    rdata_c = '0;
    case (addr)
      A_INT_EN: rdata_c = 32'(int_en);
      A_SRC:    rdata_c = 32'(src_reg);
      A_DST:    rdata_c = 32'(dst_reg);
      A_SIZE:   rdata_c = 32'(size_reg);
      A_MODE:   rdata_c = 32'(op_mode);
      A_CLEAR:  rdata_c = 32'(op_clear);
      A_STATUS: rdata_c = 32'({data_count, overflow, empty_c, full_c, op_done});
      default:  rdata_c = '0;
    endcase
  end

  // Control/setup registers and read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      int_en   <= 1'b0;
      src_reg  <= '0;
      dst_reg  <= '0;
      size_reg <= '0;
      op_mode  <= '0;
      op_clear <= 1'b0;
      op_start <= 1'b0;
      overflow <= 1'b0;
      s_dout   <= '0;
    end else begin
      op_start <= wr_c && (addr == A_START) && s_din[0];
      s_dout   <= rd_c ? rdata_c : '0;
      if (wr_c) begin
        case (addr)
          A_INT_EN: int_en   <= s_din[0];
          A_SRC:    src_reg  <= s_din[HW-1:0];
          A_DST:    dst_reg  <= s_din[HW-1:0];
          A_SIZE:   size_reg <= s_din[HW-1:0];
          A_MODE:   op_mode  <= s_din[1:0];
          A_CLEAR:  op_clear <= s_din[0];
          default:  ;
        endcase
      end
      // STATUS write and PUSH are different offsets, so never both at once
      if (wr_c && (addr == A_STATUS)) overflow <= 1'b0;
      else if (ovf_set_c)             overflow <= 1'b1;
    end
  end

  // FIFO pointers, occupancy and popped descriptor outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      data_count  <= '0;
      source_addr <= '0;
      dest_addr   <= '0;
      data_size   <= '0;
    end else begin
      data_count <= count_nxt_c;
      if (push_ok_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c) begin
        rd_ptr      <= rd_ptr + PTR_W'(1);
        source_addr <= head_c.src;
        dest_addr   <= head_c.dst;
        data_size   <= head_c.size;
      end
    end
  end

  // Descriptor storage; a push at full with a pop overwrites the slot being read out
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_ok_c) begin
      mem[wr_ptr] <= '{src: src_reg, dst: dst_reg, size: size_reg};
    end
  end

endmodule

// File: doc/dmac_slave.md
DMAC_SLAVE -- requirements
Module: dmac_slave

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk is the single clock, and reset_n is asynchronous and active-low.
REQ-002 The block SHALL expose these ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- s_sel  in  1  slave select
- s_wr  in  1  1=write, 0=read
- s_addr  in  16  register offset; only [7:0] decoded
- s_din  in  32  write data
- s_dout  out  32  read data
- op_start  out  1  start pulse to master
- op_clear  out  1  done-acknowledge level to master
- op_mode  out  2  address-increment mode to master
- op_done  in  1  master completion flag
- rd_en  in  1  descriptor pop from master
- source_addr  out  16  popped descriptor source
- dest_addr  out  16  popped descriptor destination
- data_size  out  16  popped descriptor word count
- data_count  out  4  FIFO occupancy, 0..8
- interrupt  out  1  op_done & int_en

Function
REQ-003 Register map (s_addr[7:0]) SHALL be:
- 0x00 START: write bit0=1 -> op_start pulse; reads 0
- 0x01 INT_EN: bit0, R/W
- 0x02 SRC: [15:0], R/W
- 0x03 DST: [15:0], R/W
- 0x04 SIZE: [15:0], R/W
- 0x05 PUSH: write any value -> push {SRC,DST,SIZE}; reads 0
- 0x06 MODE: [1:0], R/W
- 0x07 CLEAR: bit0, R/W
- 0x08 STATUS: RO = {data_count[7:4], overflow[3], empty[2], full[1], op_done[0]}
REQ-004 A write SHALL take effect on the clk edge where s_sel=1 and s_wr=1; unused bits SHALL be ignored on write and read as 0.
REQ-005 A read (s_sel=1, s_wr=0) SHALL register s_dout one cycle later; otherwise s_dout SHALL be 32'h0.
REQ-006 An unmapped offset SHALL read 0, and a write to it SHALL have no effect.
REQ-007 op_start SHALL be 1 for exactly the one cycle after a START write with bit0=1; back-to-back START writes SHALL give one pulse per write.
REQ-008 op_clear SHALL equal CLEAR bit0 and op_mode SHALL equal MODE[1:0], both registered levels.
REQ-009 interrupt SHALL be combinational op_done & INT_EN bit0.
REQ-010 The descriptor FIFO SHALL be 8 entries x 48 bits, with 3-bit read and write pointers wrapping 7->0, and data_count 0..8.
REQ-011 A PUSH when data_count<8 SHALL write the entry at wr_ptr and increment wr_ptr and data_count.
REQ-012 A PUSH when data_count=8 SHALL be dropped, leave pointers and count unchanged, and set the sticky overflow bit.
REQ-013 overflow SHALL be cleared by any write to STATUS.
REQ-014 rd_en=1 with data_count>0 SHALL register the entry at rd_ptr onto source_addr/dest_addr/data_size at the next edge and decrement data_count; the outputs SHALL then hold until the next pop.
REQ-015 rd_en=1 with data_count=0 SHALL be ignored, with outputs, pointers and count unchanged.
REQ-016 A simultaneous push and pop with 0<count<8 SHALL perform both and leave count unchanged.
REQ-017 A simultaneous push and pop at count=0 SHALL perform the push only, giving count=1.
REQ-018 A simultaneous push and pop at count=8 SHALL perform the pop and accept the push, with no overflow.
REQ-019 full SHALL be (data_count==8) and empty SHALL be (data_count==0), both derived from the registered count.

Reset
REQ-020 While reset_n=0, all registers, pointers, data_count, overflow, op_start, op_clear, op_mode, s_dout, source_addr, dest_addr and data_size SHALL be 0, so STATUS reads 0x04.
REQ-021 Reset asserted mid-operation SHALL discard FIFO contents immediately, without waiting for a clock edge.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset, then read STATUS -> s_dout=0x00000004 one cycle later; all outputs 0.
- Write SRC=0x0010, DST=0x0100, SIZE=0x0003, PUSH, then rd_en one cycle -> next cycle source_addr=0x0010, dest_addr=0x0100, data_size=0x0003, data_count 1->0.
- Nine PUSHes -> data_count=8, full=1, overflow=1, 9th entry absent; 8 pops return entries in order with pointer wrap; a 9th pop leaves outputs unchanged.
- Push and rd_en in the same cycle at count=0 -> count=1; at count=3 -> count stays 3 and the head entry is popped.
- START write 0x1 -> op_start high exactly one cycle; INT_EN=1 with op_done=1 -> interrupt=1; CLEAR=1 -> op_clear=1 until CLEAR=0 is written.
- Reset pulsed with 5 entries queued -> data_count=0 immediately and STATUS reads 0x04.
